// File: rtl/ipf_feeder.sv
// ---------------------------------------------------------------------------
// ipf_feeder
//
// Sequencer that drives the input side of the IPF engine for one job.
// It streams image words and weight groups out of two local read-latency-1
// buffers onto the IPF image/weight streams, then paces a compute window per
// pass with the ctrl command. Each image load is used with both weight groups,
// so a job is 2*N_IMG passes. Once all passes are issued it keeps pacing
// drain windows until IPF reports finish.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : asynchronous active-low reset
//   start    : job request, accepted only while idle
//   finish   : IPF has produced all results; ends the job from any busy state
//   busy     : job in progress (from the cycle after start until before DONE)
//   done     : one-cycle pulse when the job ends
//   i_re     : image buffer read enable
//   i_addr   : image buffer address
//   i_rdata  : image buffer read data, one cycle after i_re
//   w_re     : weight buffer read enable
//   w_addr   : weight buffer address (two groups of W_WORDS)
//   w_rdata  : weight buffer read data, one cycle after w_re
//   i_valid  : image stream valid to IPF
//   i_data   : image stream data (zero when i_valid is low)
//   w_valid  : weight stream valid to IPF
//   w_data   : weight stream data (zero when w_valid is low)
//   ctrl     : IPF command, 0 = idle/no more data, 1 = compute, 2 = advance
// ---------------------------------------------------------------------------
module ipf_feeder #(
    parameter int DATA_W    = 64,
    parameter int IMG_WORDS = 8,
    parameter int W_WORDS   = 4,
    parameter int N_IMG     = 2,
    parameter int WAIT_CYC  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 finish,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 i_re,
    output logic [$clog2(N_IMG*IMG_WORDS)-1:0]   i_addr,
    input  logic [DATA_W-1:0]                    i_rdata,
    output logic                                 w_re,
    output logic [$clog2(2*W_WORDS)-1:0]         w_addr,
    input  logic [DATA_W-1:0]                    w_rdata,
    output logic                                 i_valid,
    output logic [DATA_W-1:0]                    i_data,
    output logic                                 w_valid,
    output logic [DATA_W-1:0]                    w_data,
    output logic [2:0]                           ctrl
);

    localparam int IA_W   = $clog2(N_IMG*IMG_WORDS);
    localparam int WA_W   = $clog2(2*W_WORDS);
    localparam int CNT_W  = $clog2(IMG_WORDS + W_WORDS + WAIT_CYC + 1);
    localparam int PASS_W = $clog2(2*N_IMG);

    localparam logic [CNT_W-1:0]  IMG_LAST  = CNT_W'(IMG_WORDS - 1);
    localparam logic [CNT_W-1:0]  W_LAST    = CNT_W'(W_WORDS - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYC);
    localparam logic [WA_W-1:0]   WA_LAST   = WA_W'(2*W_WORDS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(2*N_IMG - 1);

    localparam logic [2:0] CTRL_IDLE    = 3'd0;
    localparam logic [2:0] CTRL_COMPUTE = 3'd1;
    localparam logic [2:0] CTRL_ADVANCE = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        LD_IMG,
        LD_W,
        WAIT,
        NEXT,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [IA_W-1:0]   iaddr_q, iaddr_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic              ivalid_q, wvalid_q;

    logic              active;
    logic              abort;
    logic [2:0]        heldCtrl;

    assign active = (state_q != IDLE) && (state_q != DONE);
    assign abort  = finish && active;

    // Odd passes begin straight out of an advance command and keep it on the
    // line until compute starts; even passes run their loads with ctrl idle.
    assign heldCtrl = pass_q[0] ? CTRL_ADVANCE : CTRL_IDLE;

    // Next-state and command decode. The NEXT cycle doubles as the first read
    // of the following pass, so the load counters start at 1 after it. WAIT
    // includes one lead-in cycle (the last weight valid) before compute.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        iaddr_d = iaddr_q;
        waddr_d = waddr_q;
        i_re    = 1'b0;
        w_re    = 1'b0;
        ctrl    = CTRL_IDLE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_IMG;
                    cnt_d   = '0;
                    pass_d  = '0;
                    iaddr_d = '0;
                    waddr_d = '0;
                end
            end
            LD_IMG: begin
                i_re = 1'b1;
                if (cnt_q == IMG_LAST) begin
                    state_d = LD_W;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LD_W: begin
                w_re = 1'b1;
                ctrl = heldCtrl;
                if (cnt_q == W_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                ctrl = (cnt_q == '0) ? heldCtrl : CTRL_COMPUTE;
                if (cnt_q == WAIT_LAST) begin
                    state_d = NEXT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                ctrl = CTRL_ADVANCE;
                if (pass_q == LAST_PASS) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    pass_d = pass_q + 1'b1;
                    if (pass_q[0]) begin
                        i_re    = 1'b1;
                        state_d = (IMG_LAST == '0) ? LD_W : LD_IMG;
                        cnt_d   = (IMG_LAST == '0) ? CNT_W'(0) : CNT_W'(1);
                    end else begin
                        w_re    = 1'b1;
                        state_d = (W_LAST == '0) ? WAIT : LD_W;
                        cnt_d   = (W_LAST == '0) ? CNT_W'(0) : CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                ctrl = (cnt_q == WAIT_LAST) ? CTRL_ADVANCE : CTRL_IDLE;
                cnt_d = (cnt_q == WAIT_LAST) ? '0 : cnt_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Buffer addresses advance with every issued read; the weight address
        // wraps over both groups so consecutive passes alternate groups.
        if (i_re) begin
            iaddr_d = iaddr_q + 1'b1;
        end
        if (w_re) begin
            waddr_d = (waddr_q == WA_LAST) ? '0 : waddr_q + 1'b1;
        end

        if (abort) begin
            state_d = DONE;
        end
    end

    // State, counters and the one-cycle read-to-valid alignment. A read
    // issued in the cycle finish is seen never becomes valid, so an aborted
    // load stops on the stream at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pass_q   <= '0;
            iaddr_q  <= '0;
            waddr_q  <= '0;
            ivalid_q <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            iaddr_q  <= iaddr_d;
            waddr_q  <= waddr_d;
            ivalid_q <= i_re && !abort;
            wvalid_q <= w_re && !abort;
        end
    end

    assign busy    = active;
    assign done    = (state_q == DONE);
    assign i_addr  = iaddr_q;
    assign w_addr  = waddr_q;
    assign i_valid = ivalid_q;
    assign w_valid = wvalid_q;
    assign i_data  = ivalid_q ? i_rdata : '0;
    assign w_data  = wvalid_q ? w_rdata : '0;

endmodule

// File: tb/tb_ipf_feeder.sv
// ---------------------------------------------------------------------------
// tb_ipf_feeder
//
// Scoreboard bench for ipf_feeder. Each job pushes its expected image and
// weight stream beats (cycle + data) and point expectations (cycle, signal,
// value) into queues before it starts; a negedge monitor pops stream beats
// whenever a valid is seen and checks point expectations on their cycle.
// Cycle numbers are relative to the cycle in which start is sampled.
// ---------------------------------------------------------------------------
module tb_ipf_feeder;

    localparam int DATA_W    = 64;
    localparam int IMG_WORDS = 8;
    localparam int W_WORDS   = 4;
    localparam int N_IMG     = 2;
    localparam int WAIT_CYC  = 32;

    localparam int SIG_CTRL = 0;
    localparam int SIG_BUSY = 1;
    localparam int SIG_DONE = 2;
    localparam int SIG_IRE  = 3;
    localparam int SIG_WRE  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              finish = 1'b0;
    logic              busy, done, i_re, w_re, i_valid, w_valid;
    logic [3:0]        i_addr;
    logic [2:0]        w_addr;
    logic [DATA_W-1:0] i_rdata = '0;
    logic [DATA_W-1:0] w_rdata = '0;
    logic [DATA_W-1:0] i_data, w_data;
    logic [2:0]        ctrl;

    logic [DATA_W-1:0] iMem [16];
    logic [DATA_W-1:0] wMem [8];

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } streamItem_t;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
    } pointItem_t;

    streamItem_t iQ[$];
    streamItem_t wQ[$];
    pointItem_t  pQ[$];
    streamItem_t monItem;

    int checks = 0;
    int errors = 0;
    int tick   = 0;
    int base   = 0;
    int cur    = 0;
    bit armed  = 1'b0;

    ipf_feeder #(
        .DATA_W    (DATA_W),
        .IMG_WORDS (IMG_WORDS),
        .W_WORDS   (W_WORDS),
        .N_IMG     (N_IMG),
        .WAIT_CYC  (WAIT_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .finish  (finish),
        .busy    (busy),
        .done    (done),
        .i_re    (i_re),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .w_re    (w_re),
        .w_addr  (w_addr),
        .w_rdata (w_rdata),
        .i_valid (i_valid),
        .i_data  (i_data),
        .w_valid (w_valid),
        .w_data  (w_data),
        .ctrl    (ctrl)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter; read away from the rising edge.
    always @(posedge clk) tick <= tick + 1;

    // Read-latency-1 buffer models.
    always @(posedge clk) begin
        if (i_re) i_rdata <= iMem[i_addr];
        if (w_re) w_rdata <= wMem[w_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, tick - base);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic f);
        start  = s;
        finish = f;
    endtask

    function automatic logic [63:0] pointValue(input int sig);
        case (sig)
            SIG_CTRL: return 64'(ctrl);
            SIG_BUSY: return 64'(busy);
            SIG_DONE: return 64'(done);
            SIG_IRE:  return 64'(i_re);
            default:  return 64'(w_re);
        endcase
    endfunction

    function automatic string sigName(input int sig);
        case (sig)
            SIG_CTRL: return "ctrl";
            SIG_BUSY: return "busy";
            SIG_DONE: return "done";
            SIG_IRE:  return "i_re";
            default:  return "w_re";
        endcase
    endfunction

    // Monitor: pops a stream beat for every valid, checks idle data is zero
    // and evaluates any point expectations due this cycle.
    always @(negedge clk) begin
        if (armed) begin
            cur = tick - base;
            if (i_valid || w_valid) begin
                checkOutput("valid_exclusive", 64'(i_valid & w_valid), 64'd0);
            end
            if (i_valid) begin
                if (iQ.size() == 0) begin
                    checkOutput("i_unexpected", 64'(i_valid), 64'd0);
                end else begin
                    monItem = iQ.pop_front();
                    checkOutput("i_cycle", 64'(cur), 64'(monItem.cyc));
                    checkOutput("i_data", i_data, monItem.data);
                end
            end else begin
                checkOutput("i_data_idle", i_data, 64'd0);
            end
            if (w_valid) begin
                if (wQ.size() == 0) begin
                    checkOutput("w_unexpected", 64'(w_valid), 64'd0);
                end else begin
                    monItem = wQ.pop_front();
                    checkOutput("w_cycle", 64'(cur), 64'(monItem.cyc));
                    checkOutput("w_data", w_data, monItem.data);
                end
            end else begin
                checkOutput("w_data_idle", w_data, 64'd0);
            end
            for (int k = pQ.size() - 1; k >= 0; k--) begin
                if (pQ[k].cyc == cur) begin
                    checkOutput(sigName(pQ[k].sig), pointValue(pQ[k].sig), pQ[k].val);
                    pQ.delete(k);
                end
            end
        end
    end

    task automatic expectPoint(input int c0, input int c1, input int sig, input logic [63:0] val);
        pointItem_t p;
        for (int c = c0; c <= c1; c++) begin
            p.cyc = c;
            p.sig = sig;
            p.val = val;
            pQ.push_back(p);
        end
    endtask

    task automatic expectStream(input bit isImg, input int c0, input int n, input logic [63:0] d0);
        streamItem_t s;
        for (int k = 0; k < n; k++) begin
            s.cyc  = c0 + k;
            s.data = d0 + 64'(k);
            if (isImg) iQ.push_back(s);
            else       wQ.push_back(s);
        end
    endtask

    // Called at the +2 phase of a cycle; returns at the +2 phase of cycle n.
    task automatic waitCycle(input int n);
        while ((tick - base) < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic startJob(input logic withFinish);
        base  = tick;
        armed = 1'b1;
        applyStimulus(1'b1, withFinish);
        waitCycle(1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic endJob(input int lastCyc);
        waitCycle(lastCyc + 1);
        checkOutput("i_stream_left", 64'(iQ.size()), 64'd0);
        checkOutput("w_stream_left", 64'(wQ.size()), 64'd0);
        checkOutput("points_left", 64'(pQ.size()), 64'd0);
        armed = 1'b0;
        iQ.delete();
        wQ.delete();
        pQ.delete();
    endtask

    // Streams of a full job up to the last weight group.
    task automatic expectNominalStreams();
        expectStream(1'b1, 2, 8, 64'd0);
        expectStream(1'b1, 84, 8, 64'd8);
        expectStream(1'b0, 10, 4, 64'h100);
        expectStream(1'b0, 47, 4, 64'h104);
        expectStream(1'b0, 92, 4, 64'h100);
        expectStream(1'b0, 129, 4, 64'h104);
    endtask

    task automatic expectNominalCtrl();
        expectPoint(0, 13, SIG_CTRL, 64'd0);
        expectPoint(14, 45, SIG_CTRL, 64'd1);
        expectPoint(46, 50, SIG_CTRL, 64'd2);
        expectPoint(51, 82, SIG_CTRL, 64'd1);
        expectPoint(83, 83, SIG_CTRL, 64'd2);
        expectPoint(96, 127, SIG_CTRL, 64'd1);
        expectPoint(128, 132, SIG_CTRL, 64'd2);
        expectPoint(133, 164, SIG_CTRL, 64'd1);
        expectPoint(165, 165, SIG_CTRL, 64'd2);
        expectPoint(0, 0, SIG_BUSY, 64'd0);
        expectPoint(1, 1, SIG_BUSY, 64'd1);
        expectPoint(100, 100, SIG_BUSY, 64'd1);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) iMem[k] = 64'(k);
        for (int k = 0; k < 8; k++)  wMem[k] = 64'h100 + 64'(k);

        // Reset values and idle behaviour.
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            checkOutput("idle_busy", 64'(busy), 64'd0);
        end
        rst = 1'b0;
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_i_re", 64'(i_re), 64'd0);
        checkOutput("rst_w_re", 64'(w_re), 64'd0);
        checkOutput("rst_i_valid", 64'(i_valid), 64'd0);
        checkOutput("rst_w_valid", 64'(w_valid), 64'd0);
        checkOutput("rst_ctrl", 64'(ctrl), 64'd0);
        checkOutput("rst_i_addr", 64'(i_addr), 64'd0);
        checkOutput("rst_w_addr", 64'(w_addr), 64'd0);
        checkOutput("rst_i_data", i_data, 64'd0);
        checkOutput("rst_w_data", w_data, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Nominal job with a stray start at 20 and a long drain.
        $display("[TB] nominal job");
        expectNominalStreams();
        expectNominalCtrl();
        expectPoint(166, 197, SIG_CTRL, 64'd0);
        expectPoint(198, 198, SIG_CTRL, 64'd2);
        expectPoint(199, 200, SIG_CTRL, 64'd0);
        expectPoint(200, 200, SIG_BUSY, 64'd1);
        expectPoint(200, 200, SIG_DONE, 64'd0);
        expectPoint(201, 201, SIG_DONE, 64'd1);
        expectPoint(201, 201, SIG_BUSY, 64'd0);
        expectPoint(201, 201, SIG_CTRL, 64'd0);
        expectPoint(202, 202, SIG_DONE, 64'd0);
        startJob(1'b0);
        waitCycle(20);
        applyStimulus(1'b1, 1'b0);
        waitCycle(21);
        applyStimulus(1'b0, 1'b0);
        waitCycle(200);
        applyStimulus(1'b0, 1'b1);
        waitCycle(201);
        applyStimulus(1'b0, 1'b0);
        endJob(202);

        // Finish sampled during drain.
        $display("[TB] finish in drain");
        expectNominalStreams();
        expectNominalCtrl();
        expectPoint(166, 170, SIG_CTRL, 64'd0);
        expectPoint(170, 170, SIG_BUSY, 64'd1);
        expectPoint(171, 171, SIG_DONE, 64'd1);
        expectPoint(171, 171, SIG_BUSY, 64'd0);
        expectPoint(171, 171, SIG_CTRL, 64'd0);
        expectPoint(172, 172, SIG_DONE, 64'd0);
        expectPoint(172, 172, SIG_BUSY, 64'd0);
        startJob(1'b0);
        waitCycle(170);
        applyStimulus(1'b0, 1'b1);
        waitCycle(171);
        applyStimulus(1'b0, 1'b0);
        endJob(174);

        // Finish sampled during the image load aborts it.
        $display("[TB] finish during load");
        expectStream(1'b1, 2, 4, 64'd0);
        expectPoint(5, 5, SIG_IRE, 64'd1);
        expectPoint(5, 5, SIG_DONE, 64'd0);
        expectPoint(6, 6, SIG_DONE, 64'd1);
        expectPoint(6, 6, SIG_BUSY, 64'd0);
        expectPoint(6, 6, SIG_CTRL, 64'd0);
        expectPoint(6, 7, SIG_IRE, 64'd0);
        expectPoint(7, 7, SIG_DONE, 64'd0);
        expectPoint(6, 12, SIG_WRE, 64'd0);
        startJob(1'b0);
        waitCycle(5);
        applyStimulus(1'b0, 1'b1);
        waitCycle(6);
        applyStimulus(1'b0, 1'b0);
        endJob(12);

        // Reset asserted mid-load drops the stream immediately.
        $display("[TB] reset mid-load");
        expectStream(1'b1, 2, 3, 64'd0);
        startJob(1'b0);
        waitCycle(5);
        rst = 1'b0;
        #1;
        checkOutput("midrst_i_valid", 64'(i_valid), 64'd0);
        checkOutput("midrst_i_re", 64'(i_re), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_i_addr", 64'(i_addr), 64'd0);
        checkOutput("midrst_i_data", i_data, 64'd0);
        waitCycle(6);
        checkOutput("midrst_i_stream_left", 64'(iQ.size()), 64'd0);
        armed = 1'b0;
        iQ.delete();
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Restart after reset begins at address 0; finish at the last image word.
        $display("[TB] restart after reset");
        expectStream(1'b1, 2, 8, 64'd0);
        expectPoint(9, 9, SIG_WRE, 64'd1);
        expectPoint(10, 10, SIG_DONE, 64'd1);
        expectPoint(10, 10, SIG_WRE, 64'd0);
        startJob(1'b0);
        waitCycle(9);
        applyStimulus(1'b0, 1'b1);
        waitCycle(10);
        applyStimulus(1'b0, 1'b0);
        endJob(14);

        // finish together with start in idle is ignored.
        $display("[TB] finish with start in idle");
        expectStream(1'b1, 2, 2, 64'd0);
        expectPoint(0, 3, SIG_DONE, 64'd0);
        expectPoint(1, 3, SIG_BUSY, 64'd1);
        expectPoint(4, 4, SIG_DONE, 64'd1);
        startJob(1'b1);
        waitCycle(3);
        applyStimulus(1'b0, 1'b1);
        waitCycle(4);
        applyStimulus(1'b0, 1'b0);
        endJob(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipf_feeder.md
# ipf_feeder

Stimulus sequencer driving the IPF engine's input side: streams image words and weight groups from two local buffers into IPF over the `i_valid`/`i_data`, `w_valid`/`w_data` and `ctrl` lines, then paces compute windows until IPF raises `finish`. It is the hardware counterpart of the bench stimulus process and sits between the on-chip image/weight SRAMs and the IPF instance.

## Interface
- `DATA_W`, 64: width of image and weight words.
- `IMG_WORDS`, 8: image words per image load.
- `W_WORDS`, 4: weight words per weight group; the weight buffer holds 2×`W_WORDS` words (two groups).
- `N_IMG`, 2: image loads per job; each image load is used with both weight groups, so a job has 2×`N_IMG` passes.
- `WAIT_CYC`, 32: compute window, in cycles, per pass.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request, sampled in IDLE only.
- `finish`  in  1  from IPF: all results produced.
- `busy`  out  1  high from the cycle after start acceptance through the last cycle before DONE.
- `done`  out  1  one-cycle pulse when the job ends.
- `i_re`  out  1  image buffer read enable.
- `i_addr`  out  clog2(N_IMG×IMG_WORDS)  image buffer address.
- `i_rdata`  in  DATA_W  image buffer data, valid one cycle after `i_re`.
- `w_re`  out  1  weight buffer read enable.
- `w_addr`  out  clog2(2×W_WORDS)  weight buffer address.
- `w_rdata`  in  DATA_W  weight buffer data, valid one cycle after `w_re`.
- `i_valid`, `i_data`  out  1, DATA_W  image stream to IPF.
- `w_valid`, `w_data`  out  1, DATA_W  weight stream to IPF.
- `ctrl`  out  3  IPF command: 0 = idle/no more data, 1 = compute, 2 = advance; the value holds until it is changed.

## Operation
- States: IDLE, LD_IMG, LD_W, WAIT, NEXT, DRAIN, DONE.
- IDLE: `start`=1 goes to LD_IMG, with pass=0 and both address counters cleared.
- LD_IMG: asserts `i_re` for `IMG_WORDS` cycles at consecutive addresses, continuing from the previous image load. Goes to LD_W.
- LD_W: asserts `w_re` for `W_WORDS` cycles. `w_addr` increments and wraps from 2×`W_WORDS`−1 to 0, so group 0 and group 1 alternate.
- After the final `w_re` cycle, the next-but-one cycle sets `ctrl`=1 (the cycle between is the last `w_valid` cycle). WAIT then counts `WAIT_CYC` cycles with `ctrl`=1.
- NEXT lasts one cycle with `ctrl`=2, and read issue for the next pass begins in that same cycle:
  - even pass: LD_IMG;
  - odd pass: LD_W only, and `ctrl` stays 2 during that load;
  - after the last pass: DRAIN.
- DRAIN: `ctrl`=0 for `WAIT_CYC` cycles, then `ctrl`=2 for one cycle, repeating indefinitely.
- `finish`=1, sampled in any state other than IDLE/DONE, moves to DONE on the next cycle and aborts any load in progress. `finish` is ignored in IDLE.
- DONE lasts one cycle: `done`=1, `busy`=0, `ctrl`=0, all valids and read enables low. Then IDLE.
- `start` is ignored outside IDLE.

## Timing
- Read latency is 1. The valid outputs are `i_re`/`w_re` delayed by one register. `i_data`/`w_data` equal `i_rdata`/`w_rdata` while the matching valid is high, and 0 otherwise.
- Image and weight valids are never high in the same cycle. Image load and weight load are back-to-back with no gap.
- With `start` sampled at cycle 0:
  - `i_re` cycles 1–8, `i_valid` 2–9.
  - `w_re` 9–12, `w_valid` 10–13.
  - `ctrl`=1 from cycle 14 through 45; `ctrl`=2 at 46.
- Reset (`rst`=0) forces, asynchronously, state=IDLE, all counters=0, and every output to 0 (`ctrl`=0), including mid-job. After release, the next `start` begins from address 0.
- No stream back-pressure: IPF must accept data every valid cycle.

## Test plan
- **Reset values:** assert `rst`=0 mid-cycle while idle -> all outputs 0 immediately; `start` held low -> `busy`=0 indefinitely.
- **Nominal job:** buffers loaded with `i_mem[k]`=k and `w_mem[k]`=0x100+k; `start` at cycle 0, `finish` held 0. Required:
  - `i_valid` 2–9 with data 0..7; `w_valid` 10–13 with data 0x100..0x103; `ctrl`=1 at 14–45, `ctrl`=2 at 46.
  - `w_valid` 47–50 with data 0x104..0x107; `ctrl`=1 at 51, `ctrl`=2 at 83.
  - `i_valid` 84–91 with data 8..15; `w_valid` 92–95 with data 0x100..0x103.
  - `ctrl`=2 at 128; `w_valid` 129–132 with data 0x104..0x107; `ctrl`=2 at 165.
  - `ctrl`=0 at 166–197, `ctrl`=2 at 198.
- **Finish in DRAIN:** `finish`=1 sampled at cycle 170 -> at cycle 171 `done`=1, `busy`=0, `ctrl`=0; at 172 `done`=0, back in IDLE.
- **Finish during load:** `finish`=1 at cycle 5 -> `i_valid`=0 and `i_re`=0 from cycle 6, `done` pulse at 6, no weight reads.
- **Reset mid-load:** `rst`=0 during cycle 5 -> `i_valid` drops at once. `rst` released, then `start` -> first `i_data` is `i_mem[0]`.
- **Ignored inputs:** `start` pulsed at cycle 20 -> no effect on the sequence. `finish`=1 with `start`=1 in IDLE -> job starts and `done` stays 0.
